// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO with a valid/ready write port.
// Each frame has a start bit, WORD data bits sent LSB first, an optional odd or even
// parity bit, and STOP_BITS stop bits. While the FIFO holds data, frames go out
// back-to-back with no idle gap.
//
// Ports:
//   i_Clock      - clock; all logic runs on the rising edge
//   i_Rst_n      - asynchronous active-low reset; release is expected to be synchronised
//   i_Tx_DV      - write valid
//   i_Tx_Byte    - write data, captured when i_Tx_DV && o_Tx_Ready
//   o_Tx_Ready   - FIFO not full
//   o_Fifo_Count - words waiting in the FIFO, not counting the frame on the line
//   o_Tx_Serial  - registered serial line, idle high
//   o_Tx_Active  - high while a frame is on the line
//   o_Tx_Done    - one-cycle pulse after the last stop-bit cycle of each frame
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned WORD         = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_n,
  input  logic                        i_Tx_DV,
  input  logic [WORD-1:0]             i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW   = $clog2(WORD);

  localparam logic [CntW-1:0]   ClkLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]   WordLast = IdxW'(WORD - 1);
  localparam logic [IdxW-1:0]   StopLast = IdxW'(STOP_BITS - 1);
  localparam logic [CountW-1:0] Depth    = CountW'(FIFO_DEPTH);

  // Elaboration stops here on an illegal configuration.
  if (CLKS_PER_BIT < 2 || WORD < 5 || WORD > 9 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_param_check
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and pointers. Depth is a power of two so the pointers wrap naturally.
  logic [WORD-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              push, pop, fifo_empty;

  // Transmit FSM state.
  state_e          state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [IdxW-1:0] bit_idx_q, bit_idx_d;
  logic [IdxW-1:0] idx_nxt;
  logic [WORD-1:0] shift_q, shift_d;
  logic            serial_q, serial_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic            bit_end;
  logic            par_bit;

  // Ready depends on the count alone, so a pop while full does not open the port.
  assign o_Tx_Ready   = (count_q < Depth);
  assign push         = i_Tx_DV && o_Tx_Ready;
  assign fifo_empty   = (count_q == '0);
  assign o_Fifo_Count = count_q;
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;

  assign bit_end = (clk_cnt_q == ClkLast);
  assign idx_nxt = bit_idx_q + 1'b1;
  assign par_bit = (PARITY == 2) ? ^shift_q : ~^shift_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        serial_d  = 1'b1;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          state_d  = StStart;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == WordLast) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              state_d  = StParity;
              serial_d = par_bit;
            end else begin
              state_d  = StStop;
              serial_d = 1'b1;
            end
          end else begin
            bit_idx_d = idx_nxt;
            serial_d  = shift_q[idx_nxt];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          bit_idx_d = '0;
          serial_d  = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_idx_q == StopLast) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              pop      = 1'b1;
              shift_d  = mem_q[rd_ptr_q];
              state_d  = StStart;
              serial_d = 1'b0;
            end else begin
              state_d  = StIdle;
              serial_d = 1'b1;
              active_d = 1'b0;
            end
          end else begin
            bit_idx_d = idx_nxt;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the flushed pointers and count make old contents unreachable.
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_Tx_Byte;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Three instances cover different frame formats:
//   dut 0: WORD=8, no parity,   1 stop, 4 clk/bit, depth 4 (40-cycle frames)
//   dut 1: WORD=8, even parity, 2 stop, 4 clk/bit, depth 4 (48-cycle frames)
//   dut 2: WORD=5, odd parity,  1 stop, 3 clk/bit, depth 2 (24-cycle frames)
// Accepted writes push the expected line pattern onto a scoreboard; a monitor pops it
// when the line drops and compares the serial line, active and done every cycle.
module tb_uart_tx_fifo;

  localparam int NDut = 3;

  typedef struct {
    int          d;
    logic [15:0] bits;  // line bits in transmit order, bit 0 = start bit
    int          n;
  } frame_t;

  typedef struct {
    int          d;
    logic [7:0]  data;
    logic [15:0] bits;
    int          n;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv  [NDut];
  logic [7:0] din [NDut];
  logic       ser [NDut];
  logic       act [NDut];
  logic       dn  [NDut];
  logic       rdy [NDut];
  logic [2:0] cnt [NDut];
  logic [2:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int checks = 0;
  int errors = 0;

  frame_t exp_q[$];
  frame_t cur [NDut];
  bit     in_frame [NDut];
  bit     done_pend [NDut];
  int     cyc [NDut];

  always #5 clk = ~clk;

  assign cnt[0] = cnt_a;
  assign cnt[1] = cnt_b;
  assign cnt[2] = {1'b0, cnt_c};

  uart_tx_fifo #(
    .CLKS_PER_BIT(4), .WORD(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(din[0]),
    .o_Tx_Ready(rdy[0]), .o_Fifo_Count(cnt_a), .o_Tx_Serial(ser[0]),
    .o_Tx_Active(act[0]), .o_Tx_Done(dn[0])
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT(4), .WORD(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut_b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(din[1]),
    .o_Tx_Ready(rdy[1]), .o_Fifo_Count(cnt_b), .o_Tx_Serial(ser[1]),
    .o_Tx_Active(act[1]), .o_Tx_Done(dn[1])
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT(3), .WORD(5), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)
  ) u_dut_c (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(din[2][4:0]),
    .o_Tx_Ready(rdy[2]), .o_Fifo_Count(cnt_c), .o_Tx_Serial(ser[2]),
    .o_Tx_Active(act[2]), .o_Tx_Done(dn[2])
  );

  function automatic int cpb(input int d);
    return (d == 2) ? 3 : 4;
  endfunction

  // Frame for dut 0: start 0, eight data bits LSB first, one stop bit.
  function automatic logic [15:0] a_bits(input logic [7:0] v);
    return 16'({1'b1, v, 1'b0});
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Called just after a falling edge; returns one clock later at the next falling edge.
  task automatic put(input int d, input logic [7:0] v, input bit acc,
                     input logic [15:0] bits, input int n);
    frame_t f;
    dv[d]  = 1'b1;
    din[d] = v;
    chk($sformatf("ready_dut%0d_byte%0h", d, v), rdy[d], acc);
    if (acc) begin
      f.d = d;
      f.bits = bits;
      f.n = n;
      exp_q.push_back(f);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame[0] || in_frame[1] || in_frame[2]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, n < 500, 1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: cycle-exact comparison against the scoreboard entry of the frame in flight.
  always @(negedge clk) begin
    for (int d = 0; d < NDut; d++) begin
      if (!rst_n) begin
        in_frame[d]  = 1'b0;
        done_pend[d] = 1'b0;
      end else begin
        chk($sformatf("done_dut%0d", d), dn[d], done_pend[d]);
        done_pend[d] = 1'b0;
        if (!in_frame[d] && ser[d] == 1'b0) begin
          if (exp_q.size() == 0 || exp_q[0].d != d) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame dut%0d: got start bit, want no frame", d);
            cur[d].d = d;
            cur[d].bits = '0;
            cur[d].n = 1;
          end else begin
            cur[d] = exp_q.pop_front();
          end
          in_frame[d] = 1'b1;
          cyc[d] = 0;
        end else if (in_frame[d]) begin
          cyc[d]++;
        end
        if (in_frame[d]) begin
          chk($sformatf("serial_dut%0d_cyc%0d", d, cyc[d]), ser[d],
              cur[d].bits[cyc[d] / cpb(d)]);
          chk($sformatf("active_dut%0d_cyc%0d", d, cyc[d]), act[d], 1);
          if (cyc[d] == cur[d].n * cpb(d) - 1) begin
            in_frame[d]  = 1'b0;
            done_pend[d] = 1'b1;
          end
        end else begin
          chk($sformatf("idle_active_dut%0d", d), act[d], 0);
        end
      end
    end
  end

  initial begin
    vec_t vecs [7];
    int   d, n, t1, t2;
    bit   low_ok;

    for (int i = 0; i < NDut; i++) begin
      dv[i]  = 1'b0;
      din[i] = '0;
    end

    vecs[0] = '{0, 8'hA5, 16'({1'b1, 8'hA5, 1'b0}), 10};
    vecs[1] = '{0, 8'h5A, 16'({1'b1, 8'h5A, 1'b0}), 10};
    vecs[2] = '{1, 8'h07, 16'({2'b11, 1'b1, 8'h07, 1'b0}), 12};
    vecs[3] = '{1, 8'h80, 16'({2'b11, 1'b1, 8'h80, 1'b0}), 12};
    vecs[4] = '{2, 8'hF5, 16'({1'b1, 1'b0, 5'h15, 1'b0}), 8};
    vecs[5] = '{2, 8'h03, 16'({1'b1, 1'b1, 5'h03, 1'b0}), 8};
    vecs[6] = '{2, 8'h00, 16'({1'b1, 1'b1, 5'h00, 1'b0}), 8};

    // Reset state.
    repeat (2) @(negedge clk);
    for (int i = 0; i < NDut; i++) begin
      chk($sformatf("rst_serial_dut%0d", i), ser[i], 1);
      chk($sformatf("rst_active_dut%0d", i), act[i], 0);
      chk($sformatf("rst_done_dut%0d", i), dn[i], 0);
      chk($sformatf("rst_count_dut%0d", i), cnt[i], 0);
      chk($sformatf("rst_ready_dut%0d", i), rdy[i], 1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single frames from idle, including write-to-start latency.
    for (int i = 0; i < 7; i++) begin
      d = vecs[i].d;
      put(d, vecs[i].data, 1'b1, vecs[i].bits, vecs[i].n);
      dv[d] = 1'b0;
      chk($sformatf("lat_count_vec%0d", i), cnt[d], 1);
      chk($sformatf("lat_idle_vec%0d", i), ser[d], 1);
      @(negedge clk);
      chk($sformatf("lat_start_vec%0d", i), ser[d], 0);
      chk($sformatf("lat_active_vec%0d", i), act[d], 1);
      chk($sformatf("lat_popped_vec%0d", i), cnt[d], 0);
      wait_idle($sformatf("vec%0d", i));
    end

    // Overfill: seven writes, five accepted (one in flight plus four queued).
    for (int i = 1; i <= 7; i++) put(0, 8'(i), i <= 5, a_bits(8'(i)), 10);
    dv[0] = 1'b0;
    chk("full_count", cnt[0], 4);
    chk("full_ready", rdy[0], 0);
    low_ok = 1'b1;
    n = 0;
    while (!dn[0] && n < 100) begin
      if (rdy[0]) low_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("full_done_timeout", n < 100, 1);
    chk("ready_low_until_pop", low_ok, 1);
    chk("count_after_pop", cnt[0], 3);
    chk("ready_after_pop", rdy[0], 1);
    wait_idle("fifo_order");

    // Back-to-back frames with two stop bits: done pulses one frame apart.
    put(1, 8'h00, 1'b1, 16'({2'b11, 1'b0, 8'h00, 1'b0}), 12);
    put(1, 8'hFF, 1'b1, 16'({2'b11, 1'b0, 8'hFF, 1'b0}), 12);
    dv[1] = 1'b0;
    t1 = -1;
    t2 = -1;
    n = 0;
    while (t2 < 0 && n < 200) begin
      if (dn[1]) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
      @(negedge clk);
      n++;
    end
    chk("b2b_second_done_seen", t2 >= 0, 1);
    chk("b2b_done_spacing", t2 - t1, 48);
    wait_idle("b2b");

    // Reset during data bit 3 with two words queued.
    put(0, 8'h10, 1'b1, a_bits(8'h10), 10);
    put(0, 8'h11, 1'b1, a_bits(8'h11), 10);
    put(0, 8'h12, 1'b1, a_bits(8'h12), 10);
    dv[0] = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_reset_count", cnt[0], 2);
    chk("pre_reset_serial", ser[0], 0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_serial", ser[0], 1);
    chk("abort_active", act[0], 0);
    chk("abort_count", cnt[0], 0);
    chk("abort_ready", rdy[0], 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put(0, 8'h3C, 1'b1, a_bits(8'h3C), 10);
    dv[0] = 1'b0;
    wait_idle("after_reset");
    repeat (60) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
